stack_game_engine: RTL

STACK_GAME_ENGINE -- requirements
Module: stack_game_engine

---
 rtl/stack_game_pkg.sv | 29 ++
 rtl/stack_overlap_unit.sv | 26 ++
 rtl/stack_game_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stack_game_pkg.sv
// rtl/stack_game_pkg.sv - shared state encoding and status codes for the stacking game
package stack_game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_MOVE  = 3'd2,
      ST_CHECK = 3'd3,
      ST_WIN   = 3'd4,
      ST_OVER  = 3'd5
   } game_state_t;

   localparam logic [1:0] GS_IDLE    = 2'b00;
   localparam logic [1:0] GS_PLAYING = 2'b01;
   localparam logic [1:0] GS_WON     = 2'b10;
   localparam logic [1:0] GS_OVER    = 2'b11;

   function automatic logic [1:0] status_of(input game_state_t s);
      logic [1:0] gs;
      case (s)
         ST_SPAWN, ST_MOVE, ST_CHECK: gs = GS_PLAYING;
         ST_WIN:                      gs = GS_WON;
         ST_OVER:                     gs = GS_OVER;
         default:                     gs = GS_IDLE;
      endcase
      return gs;
   endfunction

endpackage

// File: rtl/stack_overlap_unit.sv
// rtl/stack_overlap_unit.sv - combinational intersection of moving block and tower top
module stack_overlap_unit #(
   parameter int X_W = 8
) (
   input  logic [X_W-1:0] blk_x,
   input  logic [X_W-1:0] blk_w,
   input  logic [X_W-1:0] top_x,
   input  logic [X_W-1:0] top_w,
   output logic [X_W:0]   left,
   output logic [X_W:0]   right,
   output logic           hit
);

   logic [X_W:0] blk_r;
   logic [X_W:0] top_r;

   // One extra bit so right edges past the playfield never wrap
   always_comb begin
      blk_r = {1'b0, blk_x} + {1'b0, blk_w};
      top_r = {1'b0, top_x} + {1'b0, top_w};
      left  = (blk_x >= top_x) ? {1'b0, blk_x} : {1'b0, top_x};
      right = (blk_r <= top_r) ? blk_r : top_r;
      hit   = (right > left);
   end

endmodule

// File: rtl/stack_game_engine.sv
// rtl/stack_game_engine.sv - stacking-tower game state machine and datapath
module stack_game_engine
   import stack_game_pkg::*;
#(
   parameter int SCREEN_W    = 160,
   parameter int SCREEN_H    = 120,
   parameter int X_W         = 8,
   parameter int Y_W         = 7,
   parameter int BLOCK_H     = 8,
   parameter int INIT_W      = 40,
   parameter int MAX_CHANCES = 3,
   parameter int SCORE_W     = 7,
   parameter int STEP0       = 1,
   parameter int MAX_STEP    = 4,
   parameter int LEVEL_UP    = 4,
   parameter int SHRINK      = 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               sync,
   input  logic               start,
   input  logic               place,
   output logic [X_W-1:0]     x,
   output logic [Y_W-1:0]     y,
   output logic [X_W-1:0]     block_w,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         chance,
   output logic               o,
   output logic [1:0]         game_status
);

   localparam int XE_W  = X_W + 1;
   localparam int LVL_W = (LEVEL_UP > 1) ? $clog2(LEVEL_UP) : 1;

   localparam logic [X_W-1:0]   INIT_W_C   = X_W'(INIT_W);
   localparam logic [X_W-1:0]   TOP_X0     = X_W'((SCREEN_W - INIT_W) / 2);
   localparam logic [X_W-1:0]   STEP0_C    = X_W'(STEP0);
   localparam logic [X_W-1:0]   MAX_STEP_C = X_W'(MAX_STEP);
   localparam logic [X_W:0]     SCREEN_W_C = XE_W'(SCREEN_W);
   localparam logic [Y_W-1:0]   Y_START    = Y_W'(SCREEN_H - 2 * BLOCK_H);
   localparam logic [Y_W-1:0]   BLOCK_H_C  = Y_W'(BLOCK_H);
   localparam logic [3:0]       CHANCES_C  = 4'(MAX_CHANCES);
   localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(LEVEL_UP - 1);

   game_state_t    state;
   game_state_t    state_nxt;
   logic [X_W-1:0] top_x;
   logic [X_W-1:0] top_w;
   logic [X_W-1:0] step;
   logic [LVL_W-1:0] lvl_cnt;
   logic           dir_left;

   logic [X_W:0]   ov_left;
   logic [X_W:0]   ov_right;
   logic           ov_hit;

   logic [X_W:0]   x_ext;
   logic [X_W:0]   step_ext;
   logic [X_W:0]   x_limit;
   logic [X_W-1:0] x_nxt;
   logic           dir_nxt;

   stack_overlap_unit #(
      .X_W (X_W)
   ) u_overlap (
      .blk_x (x),
      .blk_w (block_w),
      .top_x (top_x),
      .top_w (top_w),
      .left  (ov_left),
      .right (ov_right),
      .hit   (ov_hit)
   );

   // Bounce between 0 and the rightmost legal left edge
   always_comb begin
      x_ext    = {1'b0, x};
      step_ext = {1'b0, step};
      x_limit  = SCREEN_W_C - {1'b0, block_w};
      x_nxt    = x;
      dir_nxt  = dir_left;
      if (!dir_left) begin
         if (x_ext + step_ext >= x_limit) begin
            x_nxt   = x_limit[X_W-1:0];
            dir_nxt = 1'b1;
         end else begin
            x_nxt = x + step;
         end
      end else begin
         if (x <= step) begin
            x_nxt   = '0;
            dir_nxt = 1'b0;
         end else begin
            x_nxt = x - step;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_WIN, ST_OVER: begin
            if (start) state_nxt = ST_SPAWN;
         end
         ST_SPAWN: state_nxt = ST_MOVE;
         ST_MOVE: begin
            if (place) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (ov_hit) begin
               state_nxt = (y == '0) ? ST_WIN : ST_SPAWN;
            end else begin
               state_nxt = (chance <= 4'd1) ? ST_OVER : ST_SPAWN;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign game_status = status_of(state);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x        <= '0;
         y        <= '0;
         block_w  <= INIT_W_C;
         score    <= '0;
         chance   <= CHANCES_C;
         o        <= 1'b0;
         step     <= STEP0_C;
         lvl_cnt  <= '0;
         dir_left <= 1'b0;
         top_x    <= TOP_X0;
         top_w    <= INIT_W_C;
      end else begin
         case (state)
            ST_IDLE, ST_WIN, ST_OVER: begin
               if (start) begin
                  score   <= '0;
                  o       <= 1'b0;
                  chance  <= CHANCES_C;
                  block_w <= INIT_W_C;
                  step    <= STEP0_C;
                  lvl_cnt <= '0;
                  y       <= Y_START;
                  top_x   <= TOP_X0;
                  top_w   <= INIT_W_C;
               end
            end
            ST_SPAWN: begin
               x        <= '0;
               dir_left <= 1'b0;
            end
            ST_MOVE: begin
               // A drop request wins over a same-cycle tick
               if (!place && sync) begin
                  x        <= x_nxt;
                  dir_left <= dir_nxt;
               end
            end
            ST_CHECK: begin
               if (ov_hit) begin
                  o <= 1'b1;
                  if (score != '1) score <= score + 1'b1;
                  if (SHRINK != 0) begin
                     top_x   <= ov_left[X_W-1:0];
                     top_w   <= X_W'(ov_right - ov_left);
                     block_w <= X_W'(ov_right - ov_left);
                  end else begin
                     top_x <= x;
                     top_w <= block_w;
                  end
                  if (y != '0) y <= y - BLOCK_H_C;
                  if (lvl_cnt == LVL_LAST) begin
                     lvl_cnt <= '0;
                     if (step < MAX_STEP_C) step <= step + 1'b1;
                  end else begin
                     lvl_cnt <= lvl_cnt + 1'b1;
                  end
               end else begin
                  o <= 1'b0;
                  if (chance != '0) chance <= chance - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
